// File: rtl/cell_tracker.sv
// Maps pixel coordinates onto a grid of cells: cell index (line/column) and offset
// inside the cell (ry/rx). Scan-order steps are tracked incrementally; jumps use a serial divider.
module cell_tracker #(
  parameter int C_CELL_WIDTH     = 5,
  parameter int C_CELL_HEIGHT    = 5,
  parameter int C_NUM_OF_CELLS_X = 5,
  parameter int C_NUM_OF_CELLS_Y = 5,
  parameter int C_COORD_BITS     = 10
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic                    ivalid,
  input  logic [C_COORD_BITS-1:0] ivga_x,
  input  logic [C_COORD_BITS-1:0] ivga_y,
  output logic [C_COORD_BITS-1:0] line,
  output logic [C_COORD_BITS-1:0] column,
  output logic [C_COORD_BITS-1:0] ry,
  output logic [C_COORD_BITS-1:0] rx,
  output logic                    ovalid,
  output logic                    obusy,
  output logic                    oedge,
  output logic                    oin_grid
);

  localparam int W  = C_COORD_BITS;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [W:0]    DIV_X     = (W+1)'(C_CELL_WIDTH);
  localparam logic [W:0]    DIV_Y     = (W+1)'(C_CELL_HEIGHT);
  localparam logic [W-1:0]  LAST_RX   = W'(C_CELL_WIDTH - 1);
  localparam logic [W-1:0]  LAST_RY   = W'(C_CELL_HEIGHT - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DIVIDE} state_e;
  typedef enum logic [1:0] {AX_ZERO, AX_EQUAL, AX_INC, AX_JUMP} axis_cls_e;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
  } axis_res_t;

  // dvd shifts left one bit per step and fills with quotient bits from the bottom.
  typedef struct packed {
    logic [W-1:0] dvd;
    logic [W:0]   rem;
  } div_t;

  function automatic axis_cls_e classify(input logic [W-1:0] coord, input logic [W-1:0] prev);
    if (coord == '0)                                      return AX_ZERO;
    else if (coord == prev)                               return AX_EQUAL;
    else if ({1'b0, coord} == ({1'b0, prev} + (W+1)'(1))) return AX_INC;
    else                                                  return AX_JUMP;
  endfunction

  function automatic axis_res_t track_step(input axis_cls_e cls, input axis_res_t cur,
                                           input logic [W-1:0] last_rem);
    axis_res_t nxt;
    nxt = cur;
    case (cls)
      AX_ZERO: nxt = '0;
      AX_INC: begin
        if (cur.rem == last_rem) begin
          nxt.rem = '0;
          nxt.quo = cur.quo + W'(1);
        end else begin
          nxt.rem = cur.rem + W'(1);
        end
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic div_t div_step(input div_t cur, input logic [W:0] divisor);
    div_t       nxt;
    logic [W:0] trial;
    logic       fits;
    trial   = {cur.rem[W-1:0], cur.dvd[W-1]};
    fits    = (trial >= divisor);
    nxt.rem = fits ? (trial - divisor) : trial;
    nxt.dvd = (cur.dvd << 1) | W'(fits);
    return nxt;
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  axis_res_t       res_x_q, res_x_d, res_y_q, res_y_d;
  div_t            div_x_q, div_x_d, div_y_q, div_y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovalid_q, ovalid_d;
  logic            oedge_q, oedge_d;
  logic            oin_grid_q, oin_grid_d;

  axis_cls_e       cls_x, cls_y;
  div_t            div_x_nxt, div_y_nxt;
  logic            load;

  always_comb begin
    cls_x     = classify(ivga_x, prev_x_q);
    cls_y     = classify(ivga_y, prev_y_q);
    div_x_nxt = div_step(div_x_q, DIV_X);
    div_y_nxt = div_step(div_y_q, DIV_Y);
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    res_x_d    = res_x_q;
    res_y_d    = res_y_q;
    div_x_d    = div_x_q;
    div_y_d    = div_y_q;
    cnt_d      = cnt_q;
    ovalid_d   = 1'b0;
    oedge_d    = oedge_q;
    oin_grid_d = oin_grid_q;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ivalid) begin
          prev_x_d = ivga_x;
          prev_y_d = ivga_y;
          if (ivga_x == '0 && ivga_y == '0) begin
            res_x_d  = '0;
            res_y_d  = '0;
            ovalid_d = 1'b1;
            load     = 1'b1;
            state_d  = S_TRACK;
          end else begin
            div_x_d = '{dvd: ivga_x, rem: '0};
            div_y_d = '{dvd: ivga_y, rem: '0};
            cnt_d   = '0;
            state_d = S_DIVIDE;
          end
        end
      end

      S_TRACK: begin
        if (ivalid) begin
          prev_x_d = ivga_x;
          prev_y_d = ivga_y;
          if (cls_x == AX_JUMP || cls_y == AX_JUMP) begin
            div_x_d = '{dvd: ivga_x, rem: '0};
            div_y_d = '{dvd: ivga_y, rem: '0};
            cnt_d   = '0;
            state_d = S_DIVIDE;
          end else begin
            res_x_d  = track_step(cls_x, res_x_q, LAST_RX);
            res_y_d  = track_step(cls_y, res_y_q, LAST_RY);
            ovalid_d = 1'b1;
            load     = 1'b1;
          end
        end
      end

      S_DIVIDE: begin
        div_x_d = div_x_nxt;
        div_y_d = div_y_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          res_x_d  = '{quo: div_x_nxt.dvd, rem: div_x_nxt.rem[W-1:0]};
          res_y_d  = '{quo: div_y_nxt.dvd, rem: div_y_nxt.rem[W-1:0]};
          cnt_d    = '0;
          ovalid_d = 1'b1;
          load     = 1'b1;
          state_d  = S_TRACK;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flags follow freshly loaded results only, so they stay 0 out of reset until a result exists.
    if (load) begin
      oedge_d    = (res_x_d.rem == '0) || (res_y_d.rem == '0);
      oin_grid_d = (32'(res_x_d.quo) < 32'(C_NUM_OF_CELLS_X)) &&
                   (32'(res_y_d.quo) < 32'(C_NUM_OF_CELLS_Y));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the divider datapath is reset too,
  // since a reset can land mid-division and everything must restart from a clean state.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= S_IDLE;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      res_x_q    <= '0;
      res_y_q    <= '0;
      div_x_q    <= '0;
      div_y_q    <= '0;
      cnt_q      <= '0;
      ovalid_q   <= 1'b0;
      oedge_q    <= 1'b0;
      oin_grid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      res_x_q    <= res_x_d;
      res_y_q    <= res_y_d;
      div_x_q    <= div_x_d;
      div_y_q    <= div_y_d;
      cnt_q      <= cnt_d;
      ovalid_q   <= ovalid_d;
      oedge_q    <= oedge_d;
      oin_grid_q <= oin_grid_d;
    end
  end

  assign column   = res_x_q.quo;
  assign rx       = res_x_q.rem;
  assign line     = res_y_q.quo;
  assign ry       = res_y_q.rem;
  assign ovalid   = ovalid_q;
  assign obusy    = (state_q == S_DIVIDE);
  assign oedge    = oedge_q;
  assign oin_grid = oin_grid_q;

endmodule

// File: tb/tb_cell_tracker.sv
// Directed bench for cell_tracker with a 5x5-pixel cell grid and 10-bit coordinates.
module tb_cell_tracker;

  logic       clk;
  logic       rst_n;
  logic       ivalid;
  logic [9:0] ivga_x, ivga_y;
  logic [9:0] line, column, ry, rx;
  logic       ovalid, obusy, oedge, oin_grid;

  int total = 0;
  int bad   = 0;

  cell_tracker #(
    .C_CELL_WIDTH(5), .C_CELL_HEIGHT(5),
    .C_NUM_OF_CELLS_X(5), .C_NUM_OF_CELLS_Y(5), .C_COORD_BITS(10)
  ) dut (
    .iclk(clk), .irst_n(rst_n), .ivalid(ivalid), .ivga_x(ivga_x), .ivga_y(ivga_y),
    .line(line), .column(column), .ry(ry), .rx(rx),
    .ovalid(ovalid), .obusy(obusy), .oedge(oedge), .oin_grid(oin_grid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [9:0] x, y;
    logic       e_valid;
    logic [9:0] e_line, e_col, e_ry, e_rx;
    logic       e_edge, e_grid, e_busy;
  } vec_t;

  vec_t vecs[20];
  int   nvec = 0;

  function automatic vec_t mk(logic v, logic [9:0] x, logic [9:0] y, logic ev,
                              logic [9:0] el, logic [9:0] ec, logic [9:0] ery, logic [9:0] erx,
                              logic ee, logic eg, logic eb);
    vec_t r;
    r.valid = v; r.x = x; r.y = y; r.e_valid = ev;
    r.e_line = el; r.e_col = ec; r.e_ry = ery; r.e_rx = erx;
    r.e_edge = ee; r.e_grid = eg; r.e_busy = eb;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [9:0] el,
                            input logic [9:0] ec, input logic [9:0] ery, input logic [9:0] erx,
                            input logic ee, input logic eg, input logic eb);
    check({tag, ".ovalid"},   32'(ovalid),   32'(ev));
    check({tag, ".line"},     32'(line),     32'(el));
    check({tag, ".column"},   32'(column),   32'(ec));
    check({tag, ".ry"},       32'(ry),       32'(ery));
    check({tag, ".rx"},       32'(rx),       32'(erx));
    check({tag, ".oedge"},    32'(oedge),    32'(ee));
    check({tag, ".oin_grid"}, 32'(oin_grid), 32'(eg));
    check({tag, ".obusy"},    32'(obusy),    32'(eb));
  endtask

  // Samples land 1ns after each rising edge, well away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y);
    ivalid = v;
    ivga_x = x;
    ivga_y = y;
  endtask

  // Counts busy cycles starting from the sample right after the input edge.
  task automatic wait_result(input string tag, output int busy_cycles);
    busy_cycles = 0;
    while (obusy && busy_cycles < 40) begin
      busy_cycles++;
      if (ovalid) check({tag, ".ovalid_during_busy"}, 32'(ovalid), 32'd0);
      step();
    end
    check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd10);
  endtask

  initial begin
    int bc;

    // Scan-order sweep from the origin, then holds and per-axis equal/inc/zero mixes.
    vecs[nvec++] = mk(1, 0, 0,  1, 0, 0, 0, 0, 1, 1, 0);
    vecs[nvec++] = mk(1, 1, 0,  1, 0, 0, 0, 1, 1, 1, 0);
    vecs[nvec++] = mk(1, 2, 0,  1, 0, 0, 0, 2, 1, 1, 0);
    vecs[nvec++] = mk(1, 3, 0,  1, 0, 0, 0, 3, 1, 1, 0);
    vecs[nvec++] = mk(1, 4, 0,  1, 0, 0, 0, 4, 1, 1, 0);
    vecs[nvec++] = mk(1, 5, 0,  1, 0, 1, 0, 0, 1, 1, 0);
    vecs[nvec++] = mk(1, 6, 0,  1, 0, 1, 0, 1, 1, 1, 0);
    vecs[nvec++] = mk(1, 7, 0,  1, 0, 1, 0, 2, 1, 1, 0);
    vecs[nvec++] = mk(1, 8, 0,  1, 0, 1, 0, 3, 1, 1, 0);
    vecs[nvec++] = mk(1, 9, 0,  1, 0, 1, 0, 4, 1, 1, 0);
    vecs[nvec++] = mk(1, 10, 0, 1, 0, 2, 0, 0, 1, 1, 0);
    vecs[nvec++] = mk(1, 11, 0, 1, 0, 2, 0, 1, 1, 1, 0);
    vecs[nvec++] = mk(1, 12, 0, 1, 0, 2, 0, 2, 1, 1, 0);
    vecs[nvec++] = mk(0, 12, 0, 0, 0, 2, 0, 2, 1, 1, 0);
    vecs[nvec++] = mk(1, 12, 0, 1, 0, 2, 0, 2, 1, 1, 0);
    vecs[nvec++] = mk(1, 12, 1, 1, 0, 2, 1, 2, 0, 1, 0);
    vecs[nvec++] = mk(1, 13, 2, 1, 0, 2, 2, 3, 0, 1, 0);
    vecs[nvec++] = mk(1, 0, 2,  1, 0, 0, 2, 0, 1, 1, 0);

    rst_n = 1'b0;
    drive(0, 0, 0);
    repeat (3) step();
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    check_outs("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].valid, vecs[i].x, vecs[i].y);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_line, vecs[i].e_col,
                 vecs[i].e_ry, vecs[i].e_rx, vecs[i].e_edge, vecs[i].e_grid, vecs[i].e_busy);
    end

    // Jump to (637,479): outputs hold while dividing; a strobe during DIVIDE must be dropped.
    drive(1, 637, 479);
    step();
    check_outs("jump_start", 0, 0, 0, 2, 0, 1, 1, 1);
    drive(1, 1, 1);
    wait_result("jump", bc);
    drive(0, 0, 0);
    check_outs("jump_result", 1, 95, 127, 4, 2, 0, 0, 0);
    drive(1, 638, 479);
    step();
    check_outs("after_jump_inc", 1, 95, 127, 4, 3, 0, 0, 0);

    // (0,4) forces a divide on y; (0,5) then wraps ry into the next line.
    drive(1, 0, 4);
    step();
    drive(0, 0, 0);
    wait_result("y_jump", bc);
    check_outs("y_jump_result", 1, 0, 0, 4, 0, 1, 1, 0);
    drive(1, 0, 5);
    step();
    check_outs("y_wrap", 1, 1, 0, 0, 0, 1, 1, 0);
    step();
    check_outs("y_repeat", 1, 1, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 5);
    step();
    check_outs("y_idle", 0, 1, 0, 0, 0, 1, 1, 0);

    // Asynchronous reset on the 4th DIVIDE cycle, then a fresh coordinate from IDLE.
    drive(1, 637, 479);
    step();
    drive(0, 0, 0);
    repeat (3) step();
    check("mid_div.busy_before_reset", 32'(obusy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("mid_div_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    step();
    check_outs("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 3);
    step();
    drive(0, 0, 0);
    wait_result("post_reset_div", bc);
    check_outs("post_reset_result", 1, 0, 0, 3, 3, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
